// File: rtl/debounce_event_channel.sv
// One debounced GPIO channel: 2-flop synchroniser, sample history, level, edge pulses
// and a saturating long-press hold counter. Sampling is paced by the shared tick.
module debounce_event_channel #(
    parameter int unsigned N          = 4,
    parameter int unsigned HOLD_TICKS = 250,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long_press
);

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned    HoldW    = clog2(HOLD_TICKS + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_TICKS);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);

    logic             sync1_q, sync2_q;
    logic [N-1:0]     hist_q, hist_d;
    logic             upd_q;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             lp_q, lp_d;
    logic [HoldW-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= INIT_LEVEL;
            sync2_q <= INIT_LEVEL;
            hist_q  <= {N{INIT_LEVEL}};
            upd_q   <= 1'b0;
            out_q   <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            lp_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            upd_q   <= tick;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            lp_q    <= lp_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[N-2:0], sync2_q};
        end
    end

    // The level is re-evaluated one cycle after each tick, once the new sample is in history.
    always_comb begin
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (upd_q) begin
            if (&hist_q) begin
                out_d  = 1'b1;
                rise_d = ~out_q;
            end else if (~|hist_q) begin
                out_d  = 1'b0;
                fall_d = out_q;
            end
        end
    end

    // Saturating at HoldMax means the long-press pulse fires once per press.
    always_comb begin
        hold_d = hold_q;
        lp_d   = 1'b0;
        if (!out_q) begin
            hold_d = '0;
        end else if (tick && (hold_q < HoldMax)) begin
            hold_d = hold_q + HoldW'(1);
            lp_d   = (hold_q == HoldLast);
        end
    end

    assign out        = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = lp_q;

endmodule

// File: rtl/debounce_event.sv
// Multi-channel GPIO debouncer with rise/fall/long-press events. Owns the shared
// sample prescaler; per-channel logic lives in debounce_event_channel.
module debounce_event #(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned N          = 4,
    parameter int unsigned RATE       = 125000,
    parameter int unsigned HOLD_TICKS = 250,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] long_press,
    output logic             tick
);

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // RATE=1 still needs a 1-bit counter; it simply stays at zero.
    localparam int unsigned     CntW   = (RATE > 1) ? clog2(RATE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(RATE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        tick_d = (cnt_q == CntMax);
        cnt_d  = tick_d ? '0 : cnt_q + CntW'(1);
    end

    assign tick = tick_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_event_channel #(
            .N          (N),
            .HOLD_TICKS (HOLD_TICKS),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick_q),
            .in         (in[i]),
            .out        (out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: doc/debounce_event.md
Name: debounce_event

Overview:
- Parametrised successor to the team's switch debouncer for board GPIO (buttons, DIP switches).
- Synchronises WIDTH asynchronous inputs and debounces them on a shared prescaled sample tick.
- Produces debounced levels plus per-channel rise, fall and long-press event pulses.
- Sits between the board pins and fpga_core in the 125 MHz clk domain.

Parameters:
- WIDTH, 9, number of independent input channels.
- N, 4, consecutive equal samples required to change a debounced level (N >= 2).
- RATE, 125000, clk cycles per sample tick (RATE >= 1).
- HOLD_TICKS, 250, sample ticks the debounced level must stay high to fire a long-press event (>= 1).
- INIT_LEVEL, 1'b0, reset value of every debounced level and sample history bit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  raw asynchronous inputs.
- out  output  WIDTH  debounced levels.
- rise  output  WIDTH  one-cycle pulse when out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when out[i] goes 1->0.
- long_press  output  WIDTH  one-cycle pulse when out[i] has been high for HOLD_TICKS ticks.
- tick  output  1  one-cycle sample strobe, for observation and test.

Behaviour:
- Reset: rst_n low clears everything asynchronously, with no clock needed.
  - Prescaler goes to 0.
  - Synchroniser flops and history bits go to INIT_LEVEL; out = {WIDTH{INIT_LEVEL}}.
  - rise, fall, long_press and tick go to 0; hold counters go to 0.
  - Reset deassertion produces no events.
- Synchroniser: 2-flop chain per channel gives in_sync, with 2 clk latency.
- Prescaler: counter of width clog2(RATE), counts 0..RATE-1 and wraps.
  - tick is a registered pulse, high for exactly one cycle after the counter reaches RATE-1.
  - RATE=1 makes tick high every cycle.
- Sampling: each cycle with tick=1, history[i] shifts left by one and takes in_sync[i] as the new LSB.
- Level update: on the cycle after a tick, out[i] follows the history.
  - history all ones: out[i] <= 1.
  - history all zeros: out[i] <= 0.
  - otherwise out[i] holds.
  - out changes only in that cycle.
- Edge events: rise[i] and fall[i] are registered alongside out.
  - They are high in the same cycle out[i] first shows its new value, for exactly one cycle.
  - They are never both high together.
- Hold counter, per channel, width clog2(HOLD_TICKS+1):
  - Cleared whenever out[i]=0.
  - Increments on each tick while out[i]=1 and the counter is below HOLD_TICKS; saturates at HOLD_TICKS.
  - long_press[i] pulses for one cycle on the increment that reaches HOLD_TICKS. There is no repeat while held.
  - After fall, a new press can fire again.
- Simultaneous events: channels are fully independent, so several channels may pulse in the same cycle.
- Reset mid-count: rst_n asserted at any point aborts counts and pulses immediately and returns to the reset state.
- Worst-case latency from an input edge to the out change: 2 + N*RATE + 1 clk.
- Glitch rejection: any input pulse shorter than (N-1)*RATE clk never reaches out.

Decomposition:
- No shared package. clog2 is a local constant function; all widths derive from parameters.
- One natural sub-module, debounce_event_channel, generated WIDTH times. It holds the synchroniser, history, level, edge and hold-counter logic for one channel.
- The top level holds the shared prescaler and tick.

Test Plan:
All scenarios use WIDTH=2, N=3, RATE=4, HOLD_TICKS=5, INIT_LEVEL=0 unless stated.
- Reset: rst_n low for 3 cycles with in=2'b11 -> out=0, rise=fall=long_press=tick=0. After release, tick first fires on cycle 4 and thereafter every 4th cycle.
- Glitch: in[0] high for 6 clk, then low -> out[0] stays 0 and no rise/fall pulses are seen on channel 0.
- Clean press: in[0] held high -> out[0]=1 within 15 clk of the edge. rise[0] is high for exactly 1 cycle, coincident with out[0] rising. Channel 1 is unaffected.
- Long press: keep in[0] high -> exactly one long_press[0] pulse 5 ticks (20 clk) after out[0] rose, then none for 100 further cycles.
  - Release gives one fall[0] pulse.
  - A re-press fires long_press[0] again after 5 ticks.
- Simultaneous: in=2'b11 asserted in the same cycle -> rise=2'b11 in one cycle. Later, long_press=2'b11 in one cycle.
- Reset mid-operation: assert rst_n low 3 ticks into a hold count -> outputs cleared at once, no pulse on release. INIT_LEVEL=1 variant: out=2'b11 out of reset with no rise.
